shift_arbiter: RTL and testbench
================================

# shift_arbiter

Shares one 32-bit shift datapath (logical left, logical right, arithmetic right) between two requesters, such as the ALU issue path and the address/immediate path. Each request is a valid/ready transaction carrying data, a 5-bit amount and an opcode. The block arbitrates round-robin, computes the shift, and captures the result in a one-entry output register. It returns the result on a valid/ready response channel tagged with the requester ID.

## Interface
Parameters:
- none (width fixed at 32, amount fixed at 5 bits)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- req0_valid  in  1  requester 0 has a request
- req0_ready  out  1  requester 0 granted this cycle (transfer when valid&&ready)
- req0_op  in  2  0=SLL, 1=SRL, 2=SRA, 3=illegal
- req0_data  in  32  operand
- req0_amt  in  5  shift amount
- req1_valid, req1_ready, req1_op, req1_data, req1_amt  same as requester 0, for requester 1
- res_valid  out  1  result register holds a result
- res_ready  in  1  consumer accepts the result
- res_data  out  32  shifted result
- res_id  out  1  requester that produced res_data
- res_err  out  1  request opcode was 3

## Operation
- Two states: EMPTY (res_valid=0) and FULL (res_valid=1).
- Slot free: `free = !res_valid || res_ready`.
- Grant is combinational and applies only when `free`:
  - one valid requester: it wins;
  - both valid: the requester not granted last wins.
- At most one of req0_ready/req1_ready is high. Both are 0 when not `free`.
- Grant register `last` updates only on an actual transfer.
- On transfer: res_data, res_id and res_err are captured and res_valid is set to 1.
  - res_data = shift(op, data, amt).
  - res_id = winner.
  - res_err = (op==3).
- Transitions:
  - EMPTY→FULL on transfer.
  - FULL→EMPTY when res_ready and no transfer.
  - FULL→FULL when res_ready and transfer (back-to-back), or when !res_ready (hold).
- Shift rules, all on 32 bits:
  - SLL zero-fills.
  - SRL zero-fills.
  - SRA replicates bit 31 into the vacated positions.
  - amt=0 returns data unchanged.
  - amt=31: SRA returns all bit-31; SLL returns {data[0], 31'b0}.
- Illegal op 3: res_data = data unchanged, res_err=1, transaction still completes.
- While FULL and !res_ready: res_data, res_id and res_err stay stable.
- Requesters keep valid and payload stable until ready; the block does not register request payloads before grant.

## Timing
- Reset values (async): res_valid=0, res_data=0, res_id=0, res_err=0, last=1, so requester 0 wins the first conflict.
- Latency: request transfer in cycle N → res_valid=1 with result in cycle N+1.
- Throughput: one result per cycle while res_ready=1.
- The ready outputs depend combinationally on req*_valid, res_valid and res_ready. There is no combinational path from request payload to any output.
- Reset asserted mid-transaction: the pending result is discarded, res_valid=0 immediately, and `last` returns to 1.

## Configuration
- Macro: `SHIFT_ARB_STATS_EN`.
- Defined: adds three outputs, each a 32-bit saturating counter:
  - stat_grant0: transfers from requester 0;
  - stat_grant1: transfers from requester 1;
  - stat_stall: cycles with res_valid && !res_ready.
  - All three reset to 0 and hold at 0xFFFFFFFF once reached.
- Undefined: these ports and counters are absent. Functional behaviour is otherwise identical.

## Structure
- Package `shift_pkg`:
  - opcode constants SHIFT_SLL=2'd0, SHIFT_SRL=2'd1, SHIFT_SRA=2'd2, SHIFT_ILL=2'd3;
  - width constants DATA_W=32 and AMT_W=5.
- Sub-module `shift_core`: combinational. Inputs op, data, amt; outputs result and err. The arbiter instantiates it once, fed by the winner's payload through a 2:1 mux.
- Arbiter FSM, `last` register, output register and stats counters live in shift_arbiter.

## Test plan
- Reset then single request: req0 SRA, data 0x80000000, amt 4 → next cycle res_valid=1, res_data=0xF8000000, res_id=0, res_err=0.
- Same operand via req1 as SRL, then SLL 0x00000001 amt 31 back-to-back with res_ready=1 → results 0x08000000 then 0x80000000, both res_id=1, one per cycle.
- Both requesters valid continuously, res_ready=1 → grants alternate 0,1,0,1 starting with 0 after reset; res_id follows the same sequence.
- res_ready=0 for 3 cycles while FULL → both ready outputs low, res_data stable; on res_ready=1 the next request is granted the same cycle.
- req0 op=3, data 0x1234ABCD, amt 7 → res_data=0x1234ABCD, res_err=1.
- rst pulsed asynchronously while FULL → res_valid drops without a clock edge. With `SHIFT_ARB_STATS_EN`, counters read 0 after reset and stat_stall counts exactly the stalled cycles.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared constants and types for the two-requester shift arbiter.
package shift_pkg;

  localparam int DATA_W = 32;
  localparam int AMT_W  = 5;

  localparam logic [1:0] SHIFT_SLL = 2'd0;
  localparam logic [1:0] SHIFT_SRL = 2'd1;
  localparam logic [1:0] SHIFT_SRA = 2'd2;
  localparam logic [1:0] SHIFT_ILL = 2'd3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              id;
    logic              err;
  } result_t;

endpackage

// File: rtl/shift_core.sv
// Combinational 32-bit shifter: SLL, SRL, SRA; opcode 3 passes data through and flags err.
module shift_core
  import shift_pkg::*;
(
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] data,
  input  logic [AMT_W-1:0]  amt,
  output logic [DATA_W-1:0] result,
  output logic              err
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    result = data;
    err    = 1'b0;
    case (op)
      SHIFT_SLL: result = data << amt;
      SHIFT_SRL: result = data >> amt;
      SHIFT_SRA: result = DATA_W'($signed(data) >>> amt);
      SHIFT_ILL: err    = 1'b1;
      default:   err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shift_core between two requesters, one-entry result register.
// Optional statistics counters are enabled with `SHIFT_ARB_STATS_EN.
module shift_arbiter
  import shift_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_op,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [AMT_W-1:0]  req0_amt,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_op,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [AMT_W-1:0]  req1_amt,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_id,
  output logic              res_err
`ifdef SHIFT_ARB_STATS_EN
  ,
  output logic [31:0]       stat_grant0,
  output logic [31:0]       stat_grant1,
  output logic [31:0]       stat_stall
`endif
);

  arb_state_e        r_state;
  arb_state_e        w_state_next;
  logic              r_last;
  result_t           r_res;

  logic              w_free;
  logic              w_grant0;
  logic              w_grant1;
  logic              w_xfer;
  logic [1:0]        w_op;
  logic [DATA_W-1:0] w_data;
  logic [AMT_W-1:0]  w_amt;
  logic [DATA_W-1:0] w_result;
  logic              w_err;

  // r_last holds the previous winner; requester 0 wins a conflict when r_last is 1.
  assign w_free   = (r_state == ST_EMPTY) || res_ready;
  assign w_grant0 = w_free && req0_valid && (!req1_valid || r_last);
  assign w_grant1 = w_free && req1_valid && (!req0_valid || !r_last);
  assign w_xfer   = w_grant0 || w_grant1;

  assign w_op   = w_grant1 ? req1_op   : req0_op;
  assign w_data = w_grant1 ? req1_data : req0_data;
  assign w_amt  = w_grant1 ? req1_amt  : req0_amt;

  shift_core u_core (
    .op     (w_op),
    .data   (w_data),
    .amt    (w_amt),
    .result (w_result),
    .err    (w_err)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_EMPTY: if (w_xfer)                w_state_next = ST_FULL;
      ST_FULL:  if (res_ready && !w_xfer)  w_state_next = ST_EMPTY;
      default:                             w_state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res  <= '0;
      r_last <= 1'b1;
    end else if (w_xfer) begin
      r_res  <= '{data: w_result, id: w_grant1, err: w_err};
      r_last <= w_grant1;
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign res_valid  = (r_state == ST_FULL);
  assign res_data   = r_res.data;
  assign res_id     = r_res.id;
  assign res_err    = r_res.err;

`ifdef SHIFT_ARB_STATS_EN
  localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

  logic [31:0] r_stat_grant0;
  logic [31:0] r_stat_grant1;
  logic [31:0] r_stat_stall;

  // Counters saturate rather than wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_grant0 <= '0;
      r_stat_grant1 <= '0;
      r_stat_stall  <= '0;
    end else begin
      if (w_grant0 && r_stat_grant0 != STAT_MAX) r_stat_grant0 <= r_stat_grant0 + 32'd1;
      if (w_grant1 && r_stat_grant1 != STAT_MAX) r_stat_grant1 <= r_stat_grant1 + 32'd1;
      if (res_valid && !res_ready && r_stat_stall != STAT_MAX)
        r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_grant0 = r_stat_grant0;
  assign stat_grant1 = r_stat_grant1;
  assign stat_stall  = r_stat_stall;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: vector table, random traffic, stall and async-reset sequences.
module tb_shift_arbiter;
  import shift_pkg::*;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [4:0]  amt;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        id;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]  req0_op, req1_op;
  logic [31:0] req0_data, req1_data;
  logic [4:0]  req0_amt, req1_amt;
  logic        res_valid, res_ready, res_id, res_err;
  logic [31:0] res_data;
`ifdef SHIFT_ARB_STATS_EN
  logic [31:0] stat_grant0, stat_grant1, stat_stall;
`endif

  shift_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_id     (res_id),
    .res_err    (res_err)
`ifdef SHIFT_ARB_STATS_EN
    ,
    .stat_grant0 (stat_grant0),
    .stat_grant1 (stat_grant1),
    .stat_stall  (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic        m_valid, m_last, last_g0, last_g1;
  int unsigned m_stall, m_g0, m_g1;
  logic [31:0] exp0_data, exp1_data;
  logic        exp0_err, exp1_err;
  vec_t        vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Bit-serial reference shifter.
  function automatic logic [31:0] model_shift(input logic [1:0] op, input logic [31:0] d,
                                              input logic [4:0] amt);
    logic [31:0] r;
    r = d;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(amt)) begin
        case (op)
          2'd0:    r = {r[30:0], 1'b0};
          2'd1:    r = {1'b0, r[31:1]};
          2'd2:    r = {r[31], r[31:1]};
          default: r = r;
        endcase
      end
    end
    return r;
  endfunction

  task automatic set_req0(input logic [1:0] op, input logic [31:0] d, input logic [4:0] amt,
                          input logic [31:0] ed, input logic ee);
    req0_op = op; req0_data = d; req0_amt = amt; exp0_data = ed; exp0_err = ee;
  endtask

  task automatic set_req1(input logic [1:0] op, input logic [31:0] d, input logic [4:0] amt,
                          input logic [31:0] ed, input logic ee);
    req1_op = op; req1_data = d; req1_amt = amt; exp1_data = ed; exp1_err = ee;
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_last = 1'b1; m_stall = 0; m_g0 = 0; m_g1 = 0;
    last_g0 = 1'b0; last_g1 = 1'b0;
    sb.delete();
  endtask

  // One clock: check handshake and result at negedge, update scoreboard and model, end at posedge+1.
  task automatic step();
    logic m_free, g0, g1;
    exp_t e;
    @(negedge clk);
    m_free = !m_valid || res_ready;
    g0 = m_free && req0_valid && (!req1_valid || m_last);
    g1 = m_free && req1_valid && (!req0_valid || !m_last);
    check("res_valid", 32'(res_valid), 32'(m_valid));
    check("req0_ready", 32'(req0_ready), 32'(g0));
    check("req1_ready", 32'(req1_ready), 32'(g1));
    if (m_valid && res_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL sb_underflow: got result 0x%08h with no expected entry", res_data);
      end else begin
        e = sb.pop_front();
        check("res_data", res_data, e.data);
        check("res_id", 32'(res_id), 32'(e.id));
        check("res_err", 32'(res_err), 32'(e.err));
      end
    end
    if (g0) begin sb.push_back('{exp0_data, 1'b0, exp0_err}); m_g0++; end
    if (g1) begin sb.push_back('{exp1_data, 1'b1, exp1_err}); m_g1++; end
    if (m_valid && !res_ready) m_stall++;
    if (g0 || g1) begin
      m_valid = 1'b1;
      m_last  = g1;
    end else if (res_ready) begin
      m_valid = 1'b0;
    end
    last_g0 = g0;
    last_g1 = g1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] hold;
    logic        granted;

    vecs[0]  = '{2'd2, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0};
    vecs[1]  = '{2'd1, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0};
    vecs[2]  = '{2'd0, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0};
    vecs[3]  = '{2'd3, 32'h1234_ABCD, 5'd7,  32'h1234_ABCD, 1'b1};
    vecs[4]  = '{2'd0, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0};
    vecs[5]  = '{2'd2, 32'h8000_0001, 5'd31, 32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{2'd2, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 1'b0};
    vecs[7]  = '{2'd1, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 1'b0};
    vecs[8]  = '{2'd0, 32'h0000_000F, 5'd4,  32'h0000_00F0, 1'b0};
    vecs[9]  = '{2'd2, 32'h0F00_0000, 5'd8,  32'h000F_0000, 1'b0};
    vecs[10] = '{2'd0, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 1'b0};
    vecs[11] = '{2'd2, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0};

    rst = 1'b1; res_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    set_req0(2'd0, 32'h0, 5'd0, 32'h0, 1'b0);
    set_req1(2'd0, 32'h0, 5'd0, 32'h0, 1'b0);
    model_reset();
    #1;
    check("rst_valid", 32'(res_valid), 32'h0);
    check("rst_data", res_data, 32'h0);
    check("rst_id", 32'(res_id), 32'h0);
    check("rst_err", 32'(res_err), 32'h0);
`ifdef SHIFT_ARB_STATS_EN
    check("rst_stat_g0", stat_grant0, 32'h0);
    check("rst_stat_g1", stat_grant1, 32'h0);
    check("rst_stat_stall", stat_stall, 32'h0);
`endif
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;

    // Continuous conflict: grants alternate starting with requester 0.
    set_req0(2'd0, 32'h0000_0001, 5'd3, 32'h0000_0008, 1'b0);
    set_req1(2'd1, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("alt_id", 32'(res_id), 32'(k % 2));
    end

    // Consumer stalls for three cycles while FULL.
    res_ready = 1'b0;
    hold = res_data;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_data", res_data, hold);
      check("stall_readys", {30'b0, req0_ready, req1_ready}, 32'h0);
    end
    res_ready = 1'b1;
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step(); step();

    // Vector table, alternating requesters, back-to-back.
    foreach (vecs[i]) begin
      if (i % 2 == 0) begin
        set_req0(vecs[i].op, vecs[i].data, vecs[i].amt, vecs[i].exp_data, vecs[i].exp_err);
        req0_valid = 1'b1;
      end else begin
        set_req1(vecs[i].op, vecs[i].data, vecs[i].amt, vecs[i].exp_data, vecs[i].exp_err);
        req1_valid = 1'b1;
      end
      granted = 1'b0;
      for (int t = 0; t < 8 && !granted; t++) begin
        step();
        granted = last_g0 || last_g1;
      end
      if (!granted) begin
        n_checks++;
        $display("FAIL vec_grant_timeout: vector %0d never granted", i);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
    end
    step(); step();

    // Random traffic with random back-pressure; payloads held until granted.
    for (int c = 0; c < 60; c++) begin
      if (!req0_valid || last_g0) begin
        req0_valid = 1'($urandom_range(0, 1));
        req0_op = 2'($urandom_range(0, 3)); req0_data = $urandom; req0_amt = 5'($urandom_range(0, 31));
        exp0_data = model_shift(req0_op, req0_data, req0_amt); exp0_err = (req0_op == 2'd3);
      end
      if (!req1_valid || last_g1) begin
        req1_valid = 1'($urandom_range(0, 1));
        req1_op = 2'($urandom_range(0, 3)); req1_data = $urandom; req1_amt = 5'($urandom_range(0, 31));
        exp1_data = model_shift(req1_op, req1_data, req1_amt); exp1_err = (req1_op == 2'd3);
      end
      res_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    step(); step(); step();
    check("sb_drained", 32'(sb.size()), 32'h0);

    // Asynchronous reset while FULL: res_valid drops without a clock edge.
    set_req1(2'd2, 32'h8000_0000, 5'd1, 32'hC000_0000, 1'b0);
    req1_valid = 1'b1;
    step();
    req1_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(res_valid), 32'h0);
    check("async_rst_data", res_data, 32'h0);
`ifdef SHIFT_ARB_STATS_EN
    check("async_rst_stat_g0", stat_grant0, 32'h0);
    check("async_rst_stat_g1", stat_grant1, 32'h0);
    check("async_rst_stat_stall", stat_stall, 32'h0);
`endif
    #1 rst = 1'b0;
    model_reset();

    // After reset requester 0 wins the first conflict again; then stall three cycles.
    set_req0(2'd1, 32'hF000_0000, 5'd28, 32'h0000_000F, 1'b0);
    set_req1(2'd0, 32'h0000_0003, 5'd30, 32'hC000_0000, 1'b0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    step();
    check("post_rst_id", 32'(res_id), 32'h0);
    res_ready = 1'b0;
    step(); step(); step();
    res_ready = 1'b1;
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step(); step();
`ifdef SHIFT_ARB_STATS_EN
    check("stat_stall", stat_stall, 32'(m_stall));
    check("stat_grant0", stat_grant0, 32'(m_g0));
    check("stat_grant1", stat_grant1, 32'(m_g1));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
